// File: rtl/taxi_eth_stat_accum.sv
// Statistics accumulator: sums per-ID increments from the MAC stat stream into
// RAM-held counters through a forwarded 3-stage read-modify-write pipeline.
module taxi_eth_stat_accum #(
  parameter int unsigned INC_W     = 16,
  parameter int unsigned ID_W      = 8,
  parameter int unsigned CNT_COUNT = 256,
  parameter int unsigned CNT_W     = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [INC_W-1:0] s_axis_stat_tdata,
  input  logic [ID_W-1:0]  s_axis_stat_tid,
  input  logic             s_axis_stat_tuser,
  input  logic             s_axis_stat_tvalid,
  output logic             s_axis_stat_tready,
  input  logic             rd_req,
  input  logic [ID_W-1:0]  rd_addr,
  input  logic             rd_clear,
  output logic             rd_ready,
  output logic [CNT_W-1:0] rd_data,
  output logic             rd_valid,
  output logic             err_bad_id,
  output logic             init_done
);

  localparam int unsigned AW = (CNT_COUNT > 1) ? $clog2(CNT_COUNT) : 1;
  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [AW-1:0]    init_cnt_q, init_cnt_d;
  logic             init_done_q, init_done_d;

  logic             s1_valid_q, s1_valid_d;
  logic             s1_rd_q, s1_rd_d;
  logic             s1_clr_q, s1_clr_d;
  logic             s1_load_q, s1_load_d;
  logic             s1_ok_q, s1_ok_d;
  logic [ID_W-1:0]  s1_id_q, s1_id_d;
  logic [INC_W-1:0] s1_inc_q, s1_inc_d;

  logic             s2_valid_q, s2_valid_d;
  logic             s2_rd_q, s2_rd_d;
  logic             s2_clr_q, s2_clr_d;
  logic             s2_load_q, s2_load_d;
  logic             s2_ok_q, s2_ok_d;
  logic [ID_W-1:0]  s2_id_q, s2_id_d;
  logic [INC_W-1:0] s2_inc_q, s2_inc_d;
  logic [CNT_W-1:0] s2_old_q, s2_old_d;

  logic             wb_valid_q, wb_valid_d;
  logic [ID_W-1:0]  wb_id_q, wb_id_d;
  logic [CNT_W-1:0] wb_val_q, wb_val_d;

  logic             rd_valid_q, rd_valid_d;
  logic [CNT_W-1:0] rd_data_q, rd_data_d;
  logic             err_q, err_d;

  logic             run_c, rd_acc_c, st_acc_c, tid_ok_c, rd_ok_c;
  logic             s2_we_c;
  logic [CNT_W-1:0] s2_new_c;
  logic             mem_we_c;
  logic [AW-1:0]    mem_waddr_c, ram_raddr_c;
  logic [CNT_W-1:0] mem_wdata_c;

  logic [CNT_W-1:0] mem [CNT_COUNT];
  logic [CNT_W-1:0] ram_rdata_q;

  assign run_c              = (state_q == ST_RUN);
  assign s_axis_stat_tready = run_c && !rd_req;
  assign rd_ready           = run_c;
  assign rd_data            = rd_data_q;
  assign rd_valid           = rd_valid_q;
  assign err_bad_id         = err_q;
  assign init_done          = init_done_q;

  // S0: host read wins arbitration; bad stat IDs are consumed without entering the pipe
  always_comb begin
    rd_acc_c    = run_c && rd_req;
    st_acc_c    = run_c && !rd_req && s_axis_stat_tvalid;
    tid_ok_c    = 32'(s_axis_stat_tid) < CNT_COUNT;
    rd_ok_c     = 32'(rd_addr) < CNT_COUNT;
    s1_valid_d  = rd_acc_c || (st_acc_c && tid_ok_c);
    s1_rd_d     = rd_acc_c;
    s1_clr_d    = rd_clear;
    s1_load_d   = s_axis_stat_tuser;
    s1_ok_d     = rd_acc_c ? rd_ok_c : tid_ok_c;
    s1_id_d     = rd_acc_c ? rd_addr : s_axis_stat_tid;
    s1_inc_d    = s_axis_stat_tdata;
    ram_raddr_c = AW'(s1_id_d);
    err_d       = st_acc_c && !tid_ok_c;
  end

  // S2: compute the new counter value and the host read result
  always_comb begin
    s2_we_c = s2_valid_q && s2_ok_q;
    if (s2_rd_q) begin
      s2_new_c = s2_clr_q ? '0 : s2_old_q;
    end else if (s2_load_q) begin
      s2_new_c = CNT_W'(s2_inc_q);
    end else begin
      s2_new_c = s2_old_q + CNT_W'(s2_inc_q);
    end
    wb_valid_d = s2_we_c;
    wb_id_d    = s2_id_q;
    wb_val_d   = s2_new_c;
    rd_valid_d = s2_valid_q && s2_rd_q;
    rd_data_d  = rd_data_q;
    if (rd_valid_d) begin
      rd_data_d = s2_ok_q ? s2_old_q : '0;
    end
  end

  // S1: RAM data may be stale by the two newest writes (S2 now, write-back last cycle)
  always_comb begin
    s2_valid_d = s1_valid_q;
    s2_rd_d    = s1_rd_q;
    s2_clr_d   = s1_clr_q;
    s2_load_d  = s1_load_q;
    s2_ok_d    = s1_ok_q;
    s2_id_d    = s1_id_q;
    s2_inc_d   = s1_inc_q;
    if (s2_we_c && (s2_id_q == s1_id_q)) begin
      s2_old_d = s2_new_c;
    end else if (wb_valid_q && (wb_id_q == s1_id_q)) begin
      s2_old_d = wb_val_q;
    end else begin
      s2_old_d = ram_rdata_q;
    end
  end

  // FSM: clear sweep after reset, then the write port belongs to S2
  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    init_done_d = init_done_q;
    mem_we_c    = 1'b0;
    mem_waddr_c = AW'(s2_id_q);
    mem_wdata_c = s2_new_c;
    case (state_q)
      ST_INIT: begin
        mem_we_c    = 1'b1;
        mem_waddr_c = init_cnt_q;
        mem_wdata_c = '0;
        if (init_cnt_q == AW'(CNT_COUNT - 1)) begin
          state_d     = ST_RUN;
          init_done_d = 1'b1;
        end else begin
          init_cnt_d = init_cnt_q + AW'(1);
        end
      end
      default: begin
        mem_we_c = s2_we_c;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      mem[mem_waddr_c] <= mem_wdata_c;
    end
    ram_rdata_q <= mem[ram_raddr_c];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_INIT;
      init_cnt_q  <= '0;
      init_done_q <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_rd_q     <= 1'b0;
      s1_clr_q    <= 1'b0;
      s1_load_q   <= 1'b0;
      s1_ok_q     <= 1'b0;
      s1_id_q     <= '0;
      s1_inc_q    <= '0;
      s2_valid_q  <= 1'b0;
      s2_rd_q     <= 1'b0;
      s2_clr_q    <= 1'b0;
      s2_load_q   <= 1'b0;
      s2_ok_q     <= 1'b0;
      s2_id_q     <= '0;
      s2_inc_q    <= '0;
      s2_old_q    <= '0;
      wb_valid_q  <= 1'b0;
      wb_id_q     <= '0;
      wb_val_q    <= '0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      init_done_q <= init_done_d;
      s1_valid_q  <= s1_valid_d;
      s1_rd_q     <= s1_rd_d;
      s1_clr_q    <= s1_clr_d;
      s1_load_q   <= s1_load_d;
      s1_ok_q     <= s1_ok_d;
      s1_id_q     <= s1_id_d;
      s1_inc_q    <= s1_inc_d;
      s2_valid_q  <= s2_valid_d;
      s2_rd_q     <= s2_rd_d;
      s2_clr_q    <= s2_clr_d;
      s2_load_q   <= s2_load_d;
      s2_ok_q     <= s2_ok_d;
      s2_id_q     <= s2_id_d;
      s2_inc_q    <= s2_inc_d;
      s2_old_q    <= s2_old_d;
      wb_valid_q  <= wb_valid_d;
      wb_id_q     <= wb_id_d;
      wb_val_q    <= wb_val_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_taxi_eth_stat_accum.sv
// Bench for taxi_eth_stat_accum: directed vector table, random stream against an
// atomic per-op counter model, reset mid-flight, and bad-ID handling on a small config.
module tb_taxi_eth_stat_accum;

  localparam int unsigned ID_W    = 8;
  localparam int unsigned CNT_W   = 64;
  localparam int unsigned A_INC_W = 64;
  localparam int unsigned A_CNT   = 256;
  localparam int unsigned B_INC_W = 16;
  localparam int unsigned B_CNT   = 128;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [A_INC_W-1:0] a_tdata;
  logic [ID_W-1:0]    a_tid, a_rd_addr;
  logic               a_tuser, a_tvalid, a_tready;
  logic               a_rd_req, a_rd_clear, a_rd_ready, a_rd_valid, a_err, a_init_done;
  logic [CNT_W-1:0]   a_rd_data;

  logic [B_INC_W-1:0] b_tdata;
  logic [ID_W-1:0]    b_tid, b_rd_addr;
  logic               b_tuser, b_tvalid, b_tready;
  logic               b_rd_req, b_rd_clear, b_rd_ready, b_rd_valid, b_err, b_init_done;
  logic [CNT_W-1:0]   b_rd_data;

  taxi_eth_stat_accum #(.INC_W(A_INC_W), .ID_W(ID_W), .CNT_COUNT(A_CNT), .CNT_W(CNT_W)) u_dut_a (
    .clk(clk), .rst(rst),
    .s_axis_stat_tdata(a_tdata), .s_axis_stat_tid(a_tid), .s_axis_stat_tuser(a_tuser),
    .s_axis_stat_tvalid(a_tvalid), .s_axis_stat_tready(a_tready),
    .rd_req(a_rd_req), .rd_addr(a_rd_addr), .rd_clear(a_rd_clear), .rd_ready(a_rd_ready),
    .rd_data(a_rd_data), .rd_valid(a_rd_valid), .err_bad_id(a_err), .init_done(a_init_done)
  );

  taxi_eth_stat_accum #(.INC_W(B_INC_W), .ID_W(ID_W), .CNT_COUNT(B_CNT), .CNT_W(CNT_W)) u_dut_b (
    .clk(clk), .rst(rst),
    .s_axis_stat_tdata(b_tdata), .s_axis_stat_tid(b_tid), .s_axis_stat_tuser(b_tuser),
    .s_axis_stat_tvalid(b_tvalid), .s_axis_stat_tready(b_tready),
    .rd_req(b_rd_req), .rd_addr(b_rd_addr), .rd_clear(b_rd_clear), .rd_ready(b_rd_ready),
    .rd_data(b_rd_data), .rd_valid(b_rd_valid), .err_bad_id(b_err), .init_done(b_init_done)
  );

  typedef struct {
    int          due;
    logic [63:0] val;
  } rd_exp_t;

  typedef struct {
    bit          rd;
    bit          clr;
    bit          tv;
    bit          load;
    logic [7:0]  id;
    logic [63:0] data;
    logic [63:0] exp;
  } vec_t;

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  bit          run_exp = 1'b0;
  bit          st_acc;
  logic [63:0] model [A_CNT];
  rd_exp_t     rq[$];
  vec_t        vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic vec_t mk(input bit rd, input bit clr, input bit tv, input bit load,
                              input logic [7:0] id, input logic [63:0] data, input logic [63:0] exp);
    vec_t v;
    v.rd = rd; v.clr = clr; v.tv = tv; v.load = load; v.id = id; v.data = data; v.exp = exp;
    return v;
  endfunction

  // One clock of DUT A: check handshake, apply accepted op to the model, check outputs
  task automatic tick(input bit use_exp, input logic [63:0] exp_val);
    rd_exp_t e;
    bit      exp_v;
    @(negedge clk);
    chk("a_tready", 64'(a_tready), 64'(run_exp && !a_rd_req));
    chk("a_rd_ready", 64'(a_rd_ready), 64'(run_exp));
    st_acc = 1'b0;
    if (run_exp && !rst) begin
      if (a_rd_req) begin
        e.due = cyc + 3;
        e.val = use_exp ? exp_val : model[a_rd_addr];
        rq.push_back(e);
        if (a_rd_clear) model[a_rd_addr] = '0;
      end else if (a_tvalid) begin
        st_acc = 1'b1;
        model[a_tid] = a_tuser ? a_tdata : model[a_tid] + a_tdata;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    exp_v = (rq.size() > 0) && (rq[0].due == cyc);
    chk("a_rd_valid", 64'(a_rd_valid), 64'(exp_v));
    if (exp_v) begin
      chk("a_rd_data", a_rd_data, rq[0].val);
      void'(rq.pop_front());
    end
    chk("a_err_bad_id", 64'(a_err), 64'd0);
  endtask

  task automatic a_idle();
    a_tvalid = 1'b0; a_rd_req = 1'b0; a_rd_clear = 1'b0;
  endtask

  task automatic wait_init();
    for (int i = 1; i <= int'(A_CNT); i++) begin
      tick(1'b0, 64'd0);
      chk("a_init_done", 64'(a_init_done), 64'(i >= int'(A_CNT)));
      chk("b_init_done", 64'(b_init_done), 64'(i >= int'(B_CNT)));
    end
    run_exp = 1'b1;
  endtask

  task automatic new_beat();
    a_tid   = ID_W'($urandom_range(0, 15));
    a_tuser = ($urandom_range(0, 15) == 0);
    if ($urandom_range(0, 3) == 0) a_tdata = {$urandom, $urandom};
    else a_tdata = 64'($urandom_range(0, 1000));
  endtask

  task automatic b_read(input logic [7:0] addr, input logic [63:0] exp);
    b_rd_req = 1'b1; b_rd_addr = addr; b_rd_clear = 1'b0;
    @(negedge clk);
    chk("b_rd_ready", 64'(b_rd_ready), 64'd1);
    @(posedge clk); #1;
    b_rd_req = 1'b0;
    chk("b_rd_valid_early1", 64'(b_rd_valid), 64'd0);
    @(posedge clk); #1;
    chk("b_rd_valid_early2", 64'(b_rd_valid), 64'd0);
    @(posedge clk); #1;
    chk("b_rd_valid", 64'(b_rd_valid), 64'd1);
    chk("b_rd_data", b_rd_data, exp);
  endtask

  initial begin
    for (int i = 0; i < int'(A_CNT); i++) model[i] = '0;
    rst = 1'b1;
    a_tdata = '0; a_tid = '0; a_tuser = 1'b0; a_rd_addr = '0; a_idle();
    b_tdata = '0; b_tid = '0; b_tuser = 1'b0; b_tvalid = 1'b0;
    b_rd_req = 1'b0; b_rd_addr = '0; b_rd_clear = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_tready", 64'(a_tready), 64'd0);
    chk("rst_rd_ready", 64'(a_rd_ready), 64'd0);
    chk("rst_rd_valid", 64'(a_rd_valid), 64'd0);
    chk("rst_rd_data", a_rd_data, 64'd0);
    chk("rst_err", 64'(a_err), 64'd0);
    chk("rst_init_done", 64'(a_init_done), 64'd0);
    chk("rst_b_init_done", 64'(b_init_done), 64'd0);

    // A beat offered throughout INIT must not be taken
    a_tvalid = 1'b1; a_tid = 8'd7; a_tdata = 64'd1;
    rst = 1'b0;
    wait_init();
    a_idle();

    vecs.push_back(mk(1, 0, 0, 0, 8'd0,   64'd0, 64'd0));
    vecs.push_back(mk(1, 0, 0, 0, 8'd255, 64'd0, 64'd0));
    vecs.push_back(mk(1, 0, 0, 0, 8'd7,   64'd0, 64'd0));
    vecs.push_back(mk(0, 0, 1, 0, 8'd3,   64'd5, 64'd0));
    vecs.push_back(mk(0, 0, 1, 0, 8'd3,   64'd7, 64'd0));
    vecs.push_back(mk(0, 0, 1, 0, 8'd3,   64'd1, 64'd0));
    vecs.push_back(mk(1, 0, 0, 0, 8'd3,   64'd0, 64'd13));
    vecs.push_back(mk(0, 0, 1, 1, 8'd9,   64'hFFFF_FFFF_FFFF_FFFF, 64'd0));
    vecs.push_back(mk(0, 0, 1, 0, 8'd9,   64'd2, 64'd0));
    vecs.push_back(mk(1, 0, 0, 0, 8'd9,   64'd0, 64'd1));
    vecs.push_back(mk(0, 0, 1, 0, 8'd4,   64'd10, 64'd0));
    vecs.push_back(mk(1, 1, 0, 0, 8'd4,   64'd0, 64'd10));
    vecs.push_back(mk(0, 0, 1, 0, 8'd4,   64'd3, 64'd0));
    vecs.push_back(mk(0, 0, 0, 0, 8'd0,   64'd0, 64'd0));
    vecs.push_back(mk(1, 0, 0, 0, 8'd4,   64'd0, 64'd3));
    vecs.push_back(mk(0, 0, 1, 1, 8'd5,   64'd100, 64'd0));
    vecs.push_back(mk(1, 0, 0, 0, 8'd5,   64'd0, 64'd100));
    vecs.push_back(mk(0, 0, 1, 0, 8'd5,   64'd1, 64'd0));
    vecs.push_back(mk(1, 1, 0, 0, 8'd5,   64'd0, 64'd101));
    vecs.push_back(mk(1, 0, 0, 0, 8'd5,   64'd0, 64'd0));
    vecs.push_back(mk(1, 0, 0, 0, 8'd3,   64'd0, 64'd13));
    for (int i = 0; i < vecs.size(); i++) begin
      a_rd_req = vecs[i].rd; a_rd_clear = vecs[i].clr; a_rd_addr = vecs[i].id;
      a_tvalid = vecs[i].tv; a_tuser = vecs[i].load; a_tid = vecs[i].id; a_tdata = vecs[i].data;
      tick(vecs[i].rd, vecs[i].exp);
    end
    a_idle();
    repeat (4) tick(1'b0, 64'd0);

    // Continuous stream with a host read every 4th cycle; beats held until taken
    a_tvalid = 1'b1;
    new_beat();
    for (int c = 0; c < 400; c++) begin
      a_rd_req = (c % 4 == 3);
      a_rd_addr = ID_W'($urandom_range(0, 15));
      a_rd_clear = ($urandom_range(0, 3) == 0);
      tick(1'b0, 64'd0);
      if (st_acc) new_beat();
    end
    a_idle();
    repeat (4) tick(1'b0, 64'd0);
    for (int i = 0; i < 16; i++) begin
      a_rd_req = 1'b1; a_rd_clear = 1'b0; a_rd_addr = ID_W'(i);
      tick(1'b0, 64'd0);
    end
    a_idle();
    repeat (4) tick(1'b0, 64'd0);

    // Reset with a read in flight: no rd_valid, counters cleared by the re-run sweep
    a_tvalid = 1'b1; a_tid = 8'd3; a_tuser = 1'b0; a_tdata = 64'd50;
    tick(1'b0, 64'd0);
    a_tvalid = 1'b0; a_rd_req = 1'b1; a_rd_addr = 8'd3;
    tick(1'b0, 64'd0);
    a_idle();
    tick(1'b0, 64'd0);
    rst = 1'b1;
    rq.delete();
    for (int i = 0; i < int'(A_CNT); i++) model[i] = '0;
    run_exp = 1'b0;
    #1;
    chk("midrst_init_done", 64'(a_init_done), 64'd0);
    chk("midrst_rd_valid", 64'(a_rd_valid), 64'd0);
    chk("midrst_tready", 64'(a_tready), 64'd0);
    repeat (3) tick(1'b0, 64'd0);
    rst = 1'b0;
    wait_init();
    a_rd_req = 1'b1; a_rd_addr = 8'd3;
    tick(1'b1, 64'd0);
    a_rd_addr = 8'd9;
    tick(1'b1, 64'd0);
    a_idle();
    repeat (4) tick(1'b0, 64'd0);

    // Small config: tid 200 is out of range and must not alias onto counter 72
    b_tvalid = 1'b1; b_tid = 8'd72; b_tdata = 16'd9; b_tuser = 1'b0;
    @(negedge clk);
    chk("b_tready_good", 64'(b_tready), 64'd1);
    @(posedge clk); #1;
    chk("b_err_good", 64'(b_err), 64'd0);
    b_tid = 8'd200; b_tdata = 16'd5;
    @(negedge clk);
    chk("b_tready_bad", 64'(b_tready), 64'd1);
    @(posedge clk); #1;
    chk("b_err_pulse", 64'(b_err), 64'd1);
    b_tvalid = 1'b0;
    @(posedge clk); #1;
    chk("b_err_once", 64'(b_err), 64'd0);
    b_read(8'd72, 64'd9);
    b_read(8'd200, 64'd0);
    b_read(8'd127, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
